// File: rtl/fir_decimator.sv
// fir_decimator: power-of-two decimator for the fir_filter output stream,
// followed by a first-word-fall-through FIFO with a valid/ready output.
// Optional feature macro: FIR_DECIM_AVG_EN. When it is defined, each group
// of DECIM samples is averaged (boxcar). When it is undefined, the first
// sample of each group is kept and no accumulator is built.
module fir_decimator #(
    parameter int DECIM      = 4,
    parameter int LOG2_DECIM = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [15:0]       input_signal,
    input  logic                     valid_in,
    output logic signed [15:0]       output_signal,
    output logic                     valid_out,
    input  logic                     ready_in,
    output logic                     overflow,
    output logic [FIFO_AW:0]         fifo_level
);

    // A phase counter needs at least one bit, even when DECIM is 1.
    localparam int PW = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;
    localparam logic [PW-1:0]    PHASE_LAST = PW'(DECIM - 1);
    localparam logic [FIFO_AW:0] LEVEL_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);

    logic [PW-1:0]        phase_reg;
    logic signed [15:0]   dec_reg;
    logic                 dec_vld;

    logic signed [15:0]   mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr_reg;
    logic [FIFO_AW-1:0]   rd_ptr_reg;
    logic [FIFO_AW:0]     level_reg;
    logic                 overflow_reg;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;

    // Group phase: advances only on valid input samples and wraps at DECIM-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_reg <= '0;
        end else if (valid_in) begin
            phase_reg <= (phase_reg == PHASE_LAST) ? '0 : phase_reg + 1'b1;
        end
    end

`ifdef FIR_DECIM_AVG_EN
    localparam int AW = 16 + LOG2_DECIM;

    logic signed [AW-1:0] acc_reg;
    logic signed [AW-1:0] acc_base;
    logic signed [AW-1:0] sample_ext;
    logic signed [AW-1:0] acc_sum;

    // Running sum of the group; the first sample of a group reloads the sum.
    always_comb begin
        sample_ext = input_signal;
        acc_base   = (phase_reg == '0) ? '0 : acc_reg;
        acc_sum    = acc_base + sample_ext;
    end

    // Average-and-dump: on the last sample of a group emit the floored mean.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg <= '0;
            dec_reg <= '0;
            dec_vld <= 1'b0;
        end else begin
            dec_vld <= 1'b0;
            if (valid_in) begin
                acc_reg <= acc_sum;
                if (phase_reg == PHASE_LAST) begin
                    dec_reg <= 16'(acc_sum >>> LOG2_DECIM);
                    dec_vld <= 1'b1;
                end
            end
        end
    end
`else
    // Pick-first: keep the sample taken at phase 0, drop the rest of the group.
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_reg <= '0;
            dec_vld <= 1'b0;
        end else begin
            dec_vld <= 1'b0;
            if (valid_in && (phase_reg == '0)) begin
                dec_reg <= input_signal;
                dec_vld <= 1'b1;
            end
        end
    end
`endif

    // FIFO control: a full FIFO still accepts a push when the head leaves the same cycle.
    always_comb begin
        fifo_full  = (level_reg == LEVEL_FULL);
        fifo_empty = (level_reg == '0);
        pop        = !fifo_empty && ready_in;
        push       = dec_vld && (!fifo_full || pop);
    end

    // Storage array; contents need no reset because the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= dec_reg;
        end
    end

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
            if (dec_vld && !push) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Fall-through head: the read is asynchronous so a pop exposes the next
    // entry without a bubble; an empty FIFO presents zero.
    always_comb begin
        output_signal = fifo_empty ? '0 : mem[rd_ptr_reg];
        valid_out     = !fifo_empty;
        overflow      = overflow_reg;
        fifo_level    = level_reg;
    end

endmodule

// File: tb/tb_fir_decimator.sv
// Testbench for fir_decimator: a behavioural model predicts decimated samples
// and FIFO occupancy; a monitor checks every output handshake against a queue.
module tb_fir_decimator;

    localparam int DECIM      = 4;
    localparam int LOG2_DECIM = 2;
    localparam int FIFO_DEPTH = 8;
    localparam int FIFO_AW    = 3;
`ifdef FIR_DECIM_AVG_EN
    localparam bit AVG = 1'b1;
`else
    localparam bit AVG = 1'b0;
`endif
    localparam int EMIT_IDX = AVG ? DECIM - 1 : 0;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic signed [15:0]  input_signal = '0;
    logic                valid_in = 1'b0;
    logic signed [15:0]  output_signal;
    logic                valid_out;
    logic                ready_in = 1'b0;
    logic                overflow;
    logic [FIFO_AW:0]    fifo_level;

    fir_decimator #(
        .DECIM(DECIM), .LOG2_DECIM(LOG2_DECIM),
        .FIFO_DEPTH(FIFO_DEPTH), .FIFO_AW(FIFO_AW)
    ) dut (
        .clk(clk), .rst(rst), .input_signal(input_signal), .valid_in(valid_in),
        .output_signal(output_signal), .valid_out(valid_out), .ready_in(ready_in),
        .overflow(overflow), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int sb_q[$];
    int grp[$];
    int mdl_level = 0;
    bit mdl_ovf = 1'b0;
    bit pend_vld = 1'b0;
    int pend_val = 0;

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int floor_mean(int s);
        if (s >= 0) return s / DECIM;
        return -((-s + DECIM - 1) / DECIM);
    endfunction

    // Model of one clock edge given the inputs applied before it.
    task automatic model_edge(bit r_s, bit v, int x, bit r);
        bit pop_m;
        bit acc_m;
        int s;
        if (r_s) begin
            grp.delete();
            sb_q.delete();
            mdl_level = 0;
            mdl_ovf   = 1'b0;
            pend_vld  = 1'b0;
            return;
        end
        pop_m = (mdl_level > 0) && r;
        acc_m = pend_vld && ((mdl_level < FIFO_DEPTH) || pop_m);
        if (pend_vld && !acc_m) mdl_ovf = 1'b1;
        if (acc_m) sb_q.push_back(pend_val);
        mdl_level = mdl_level + int'(acc_m) - int'(pop_m);
        pend_vld = 1'b0;
        if (v) begin
            grp.push_back(x);
            if (!AVG && grp.size() == 1) begin
                pend_vld = 1'b1;
                pend_val = grp[0];
            end
            if (grp.size() == DECIM) begin
                if (AVG) begin
                    s = 0;
                    foreach (grp[k]) s += grp[k];
                    pend_vld = 1'b1;
                    pend_val = floor_mean(s);
                end
                grp.delete();
            end
        end
    endtask

    // Apply inputs for one cycle, update the model, then land 1 time unit after the edge.
    task automatic drive(bit r_s, bit v, int x, bit r);
        rst          = r_s;
        valid_in     = v;
        input_signal = 16'(x);
        ready_in     = r;
        model_edge(r_s, v, x, r);
        @(posedge clk);
        #1;
    endtask

    task automatic check_state();
        check("fifo_level", int'(fifo_level), mdl_level);
        check("overflow", int'(overflow), int'(mdl_ovf));
        check("valid_out", int'(valid_out), int'(mdl_level > 0));
    endtask

    task automatic check_cleared();
        check("rst_valid_out", int'(valid_out), 0);
        check("rst_output", int'(output_signal), 0);
        check("rst_fifo_level", int'(fifo_level), 0);
        check("rst_overflow", int'(overflow), 0);
    endtask

    // Monitor: every handshake must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && valid_out && ready_in) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got %0d expected none", output_signal);
            end else begin
                check("scoreboard_out", int'(output_signal), sb_q.pop_front());
            end
        end
    end

    initial begin
        int avg_vals[12];
        int thr;
        avg_vals = '{10, 20, 30, 41, -1, -1, -1, -2, 32767, 32767, 32767, 32767};

        // Reset values
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        check_cleared();

        // Ramp 0..15 with latency check on the emitting edge
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, i, 1);
            if (i == EMIT_IDX)     check("latency_edge_e", int'(valid_out), 0);
            if (i == EMIT_IDX + 1) check("latency_edge_e1", int'(valid_out), 1);
        end
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 1);
        check_state();

        // Averaging corner groups (also valid stimulus in pick mode)
        for (int i = 0; i < 12; i++) drive(0, 1, avg_vals[i], 1);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 1);
        check_state();

        // Gapped input
        drive(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, i, 1);
            drive(0, 0, 0, 1);
        end
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 1);
        check_state();

        // Overflow: nine decimated samples with no consumer
        drive(1, 0, 0, 0);
        for (int k = 0; k < 9; k++)
            for (int j = 0; j < DECIM; j++) drive(0, 1, 1000 + k * DECIM + j, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        check("ovf_level", int'(fifo_level), FIFO_DEPTH);
        check("ovf_flag", int'(overflow), 1);
        for (int i = 0; i < FIFO_DEPTH + 4; i++) drive(0, 0, 0, 1);
        check("ovf_drained_level", int'(fifo_level), 0);
        check("ovf_flag_sticky", int'(overflow), 1);

        // Full FIFO with push and pop on the same edge
        drive(1, 0, 0, 0);
        for (int k = 0; k < FIFO_DEPTH; k++)
            for (int j = 0; j < DECIM; j++) drive(0, 1, 2000 + k * DECIM + j, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        check("full_level", int'(fifo_level), FIFO_DEPTH);
        for (int j = 0; j <= EMIT_IDX; j++) drive(0, 1, 3000 + j, 0);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);
        check("pushpop_level", int'(fifo_level), FIFO_DEPTH);
        check("pushpop_overflow", int'(overflow), 0);

        // Reset mid-group, then a fresh group must start at phase 0
        drive(0, 1, 777, 0);
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        check_cleared();
        for (int j = 0; j < DECIM; j++) drive(0, 1, 100 + j, 1);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 1);
        check_state();

        // Randomized traffic with varying consumer rate
        drive(1, 0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            case ((c / 500) % 3)
                0:       thr = 90;
                1:       thr = 5;
                default: thr = 50;
            endcase
            drive(0, bit'($urandom_range(0, 1)), int'($urandom_range(0, 65535)) - 32768,
                  $urandom_range(0, 99) < thr);
            check_state();
        end
        for (int i = 0; i < FIFO_DEPTH + 4; i++) drive(0, 0, 0, 1);
        check("final_level", int'(fifo_level), 0);
        check("final_pending", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fir_decimator.md
# fir_decimator

Downstream stage of `fir_filter`. It takes the filter's 16-bit signed output stream (`output_signal`/`valid_out`) and reduces the sample rate by a power-of-two factor. Decimated samples are buffered in a small first-word-fall-through FIFO and delivered with a valid/ready handshake. It lets a slower consumer, such as a file writer, DMA or serializer, drain filtered data without stalling the filter, which has no backpressure input.

## Interface
Parameters:
- `DECIM`, 4: decimation factor; power of two, 1..16.
- `LOG2_DECIM`, 2: log2(`DECIM`); must match.
- `FIFO_DEPTH`, 8: FIFO entries; power of two, ≥2.
- `FIFO_AW`, 3: log2(`FIFO_DEPTH`).

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous and active-high.
- `input_signal` in 16: signed sample from `fir_filter`.
- `valid_in` in 1: `input_signal` is valid this cycle. There is no ready; every valid sample must be consumed.
- `output_signal` out 16: signed decimated sample at the FIFO head.
- `valid_out` out 1: FIFO not empty.
- `ready_in` in 1: consumer accepts `output_signal` this cycle.
- `overflow` out 1: sticky; a decimated sample was dropped because the FIFO was full.
- `fifo_level` out FIFO_AW+1: current FIFO occupancy, 0..`FIFO_DEPTH`.

## Operation
- Phase counter `phase` (LOG2_DECIM bits):
  - Advances on each `valid_in` cycle and wraps from `DECIM-1` to 0.
  - It does not advance while `valid_in` is low; gaps are allowed.
- Decimation without `FIR_DECIM_AVG_EN`:
  - The sample accepted at `phase==0` is captured into `dec_reg` and `dec_vld` is set for one cycle.
  - The other `DECIM-1` samples of the group are discarded.
- FIFO push happens when `dec_vld` is high.
  - Accepted if the FIFO is not full, or if it is full and a pop happens the same cycle.
  - Otherwise the sample is dropped, `overflow` is set to 1 and stays there until `rst`.
- FIFO pop happens when `valid_out && ready_in`.
- Output:
  - `output_signal` is always the head entry; it is a don't-care when empty but driven to 0 after reset.
  - `valid_out` equals "not empty".
- Simultaneous push and pop:
  - Level is unchanged.
  - On an empty FIFO a push and a pop cannot coincide, because `valid_out` is low.
- Pointers: read and write pointers are FIFO_AW bits and wrap modulo `FIFO_DEPTH`. Full/empty are derived from `fifo_level`.
- Reset, including mid-group or with a non-empty FIFO:
  - `phase`=0, accumulator=0, `dec_vld`=0, pointers=0, `fifo_level`=0.
  - `valid_out`=0, `output_signal`=0, `overflow`=0.
  - Partial groups and buffered data are discarded.
- `DECIM`=1 passes every sample through the FIFO.

## Timing
- All outputs are registered or derived from registered state; there is no combinational path from `valid_in` or `input_signal` to any output.
- `ready_in` affects the pop at the next edge only.
- Latency into an empty FIFO:
  - Edge E samples the selecting input (or last-of-group input under `FIR_DECIM_AVG_EN`).
  - `dec_vld` is high after E.
  - The FIFO write occurs at E+1.
  - `valid_out`=1 and `output_signal` are valid after E+1, i.e. 2 edges.
- A pop at edge P exposes the next entry after P; there is no bubble.
- Sustained throughput is one output per cycle while `ready_in`=1. Steady-state input rate is at most one sample per `DECIM` valid cycles.
- `fifo_level` updates at the same edge as the push/pop.

## Configuration
- `FIR_DECIM_AVG_EN` defined: boxcar average-and-dump.
  - A signed accumulator of 16+LOG2_DECIM bits is loaded with the first sample of the group and adds each following sample.
  - At `phase==DECIM-1` with `valid_in`, the result is (sum of `DECIM` samples) >>> `LOG2_DECIM`.
  - The shift is arithmetic and truncates toward −∞. The result always fits in 16 bits; no saturation is needed.
  - The accumulator then reloads on the next group.
- Undefined: pick-first-of-group as described above. No accumulator is synthesized.

## Test plan
- **Reset values:** assert `rst` for 2 cycles → `valid_out`=0, `output_signal`=0, `fifo_level`=0, `overflow`=0.
- **Pick mode:** `DECIM`=4; feed 0,1,2,…,15 with `valid_in`=1 and `ready_in`=1.
  - Outputs are 0,4,8,12.
  - The first `valid_out` rises 2 edges after the edge that sampled 0.
- **Average mode:** `FIR_DECIM_AVG_EN`, `DECIM`=4.
  - Group 10,20,30,41 → 25.
  - Group −1,−1,−1,−2 → −2 (floor of −1.25).
  - Group 32767×4 → 32767.
- **Gapped input:** `valid_in` toggling 1,0,1,0 with values 0..7 → outputs 0,4; phase is unaffected by the gaps.
- **Overflow:** `ready_in`=0, `FIFO_DEPTH`=8; push 9 decimated samples.
  - `fifo_level`=8 and `overflow`=1.
  - Then `ready_in`=1 → the first 8 values drain in order and the 9th is absent.
- **Full with simultaneous push/pop, then mid-operation reset:**
  - FIFO full with `ready_in`=1 on the push cycle → level stays 8, the new sample is accepted, `overflow` stays 0.
  - Then assert `rst` mid-group → everything is cleared, and the next group starts at phase 0.
